// File: rtl/cnt_capture.sv
// cnt_capture: frame receiver. It captures a 53-word payload that sits
// between a header word (10'h234) and a trailer word (10'h2BF).
// Payload words are collected in a shadow buffer. words_out is loaded from
// the shadow buffer only when a frame ends with a good trailer, so a partial
// or bad frame never changes the last good payload.
//
// Ports:
//   clk50           in   sole clock, rising edge
//   rst             in   synchronous active-high reset, highest priority
//   word_in[9:0]    in   received word, sampled when word_valid=1
//   word_valid      in   one word accepted per high cycle
//   clr_capture     in   clears the sticky flags; a same-cycle set wins
//   words_out[53]   out  last good payload, index 0 = first payload word
//   frame_done      out  one-cycle pulse, one edge after the good trailer
//   frame_done_flag out  sticky good-frame flag
//   frame_err       out  sticky bad-trailer flag
//   timeout_err     out  sticky inter-word timeout flag
//   frame_cnt[7:0]  out  good-frame count, wraps 255 -> 0
//   busy            out  high while in DATA or TRAIL
//
// Build option: CNT_CAPTURE_TIMEOUT_EN adds a 10-bit inter-word idle
// counter. Without it, timeout_err is tied to 0 and the FSM waits forever.
//
// state | meaning
// IDLE  | hunting for a header; all other words are dropped
// DATA  | storing payload words 0..52 into the shadow buffer
// TRAIL | expecting the trailer word

module cnt_capture (
   input  logic       clk50,
   input  logic       rst,
   input  logic [9:0] word_in,
   input  logic       word_valid,
   input  logic       clr_capture,
   output logic [9:0] words_out [0:52],
   output logic       frame_done,
   output logic       frame_done_flag,
   output logic       frame_err,
   output logic       timeout_err,
   output logic [7:0] frame_cnt,
   output logic       busy
);

   localparam logic [9:0] HDR_WORD = 10'h234;
   localparam logic [9:0] TRL_WORD = 10'h2BF;
   localparam logic [5:0] LAST_IDX = 6'd52;

   typedef enum logic [1:0] {IDLE, DATA, TRAIL} state_t;

   state_t     state_q, state_d;
   logic [5:0] word_idx_q, word_idx_d;
   logic [9:0] shadow_q    [0:52];
   logic [9:0] words_out_q [0:52];
   logic       frame_done_q;
   logic       done_flag_q;
   logic       frame_err_q;
   logic [7:0] frame_cnt_q;

   logic       shadow_we;
   logic       good_frame;
   logic       bad_frame;
   logic       timeout_hit;

`ifdef CNT_CAPTURE_TIMEOUT_EN
   logic [9:0] idle_cnt_q, idle_cnt_d;
   logic       timeout_err_q;

   // The counter holds at zero in IDLE. Because of that, entering DATA
   // always starts from zero. The 1023rd idle cycle in a row fires the
   // timeout (the count goes 0..1022 before it).
   always_comb begin
      idle_cnt_d  = idle_cnt_q + 10'd1;
      timeout_hit = 1'b0;
      if (state_q == IDLE || word_valid) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q == 10'd1022) begin
         timeout_hit = 1'b1;
         idle_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk50) begin
      if (rst) begin
         idle_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         if (timeout_hit)
            timeout_err_q <= 1'b1;
         else if (clr_capture)
            timeout_err_q <= 1'b0;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      shadow_we  = 1'b0;
      good_frame = 1'b0;
      bad_frame  = 1'b0;
      case (state_q)
         IDLE: begin
            if (word_valid && word_in == HDR_WORD) begin
               state_d    = DATA;
               word_idx_d = '0;
            end
         end
         DATA: begin
            if (word_valid) begin
               shadow_we  = 1'b1;
               word_idx_d = word_idx_q + 6'd1;
               if (word_idx_q == LAST_IDX)
                  state_d = TRAIL;
            end
         end
         TRAIL: begin
            if (word_valid) begin
               // A rejected trailer is consumed here and is not checked
               // again as a header.
               if (word_in == TRL_WORD)
                  good_frame = 1'b1;
               else
                  bad_frame = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (timeout_hit)
         state_d = IDLE;
   end

   always_ff @(posedge clk50) begin
      if (rst) begin
         state_q      <= IDLE;
         word_idx_q   <= '0;
         frame_done_q <= 1'b0;
         done_flag_q  <= 1'b0;
         frame_err_q  <= 1'b0;
         frame_cnt_q  <= '0;
         for (int i = 0; i < 53; i++) begin
            shadow_q[i]    <= '0;
            words_out_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         word_idx_q   <= word_idx_d;
         frame_done_q <= good_frame;
         if (shadow_we)
            shadow_q[word_idx_q] <= word_in;
         if (good_frame) begin
            words_out_q <= shadow_q;
            frame_cnt_q <= frame_cnt_q + 8'd1;
         end
         if (good_frame)
            done_flag_q <= 1'b1;
         else if (clr_capture)
            done_flag_q <= 1'b0;
         if (bad_frame)
            frame_err_q <= 1'b1;
         else if (clr_capture)
            frame_err_q <= 1'b0;
      end
   end

   assign words_out       = words_out_q;
   assign frame_done      = frame_done_q;
   assign frame_done_flag = done_flag_q;
   assign frame_err       = frame_err_q;
   assign frame_cnt       = frame_cnt_q;
   assign busy            = (state_q == DATA) || (state_q == TRAIL);

endmodule

// File: tb/tb_cnt_capture.sv
// Directed testbench for cnt_capture. It covers reset values, good frames,
// bad trailers, idle garbage, a payload that contains the header and trailer
// values, reset in the middle of a frame, frame_cnt wrap, clear/set
// priority, and the optional inter-word timeout.

module tb_cnt_capture;

   localparam logic [9:0] HDR = 10'h234;
   localparam logic [9:0] TRL = 10'h2BF;

   logic       clk50;
   logic       rst;
   logic [9:0] word_in;
   logic       word_valid;
   logic       clr_capture;
   logic [9:0] words_out [0:52];
   logic       frame_done;
   logic       frame_done_flag;
   logic       frame_err;
   logic       timeout_err;
   logic [7:0] frame_cnt;
   logic       busy;

   int         checks   = 0;
   int         failures = 0;
   int         done_cnt = 0;
   logic [9:0] pay [0:52];

   cnt_capture dut (
      .clk50           (clk50),
      .rst             (rst),
      .word_in         (word_in),
      .word_valid      (word_valid),
      .clr_capture     (clr_capture),
      .words_out       (words_out),
      .frame_done      (frame_done),
      .frame_done_flag (frame_done_flag),
      .frame_err       (frame_err),
      .timeout_err     (timeout_err),
      .frame_cnt       (frame_cnt),
      .busy            (busy)
   );

   initial begin
      clk50 = 1'b0;
      forever #5 clk50 = ~clk50;
   end

   always @(negedge clk50)
      if (frame_done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Call this at a negedge. It drives one word for one cycle and returns
   // at the negedge that is gap cycles later.
   task automatic send_word(input logic [9:0] w, input int gap, input logic clr);
      word_in     = w;
      word_valid  = 1'b1;
      clr_capture = clr;
      @(negedge clk50);
      word_valid  = 1'b0;
      clr_capture = 1'b0;
      repeat (gap - 1) @(negedge clk50);
   endtask

   task automatic send_frame(input logic [9:0] trl, input int gap, input logic clr_trl);
      send_word(HDR, gap, 1'b0);
      for (int k = 0; k < 53; k++) send_word(pay[k], gap, 1'b0);
      send_word(trl, 1, clr_trl);
   endtask

   task automatic pulse_clr();
      clr_capture = 1'b1;
      @(negedge clk50);
      clr_capture = 1'b0;
   endtask

   initial begin
      rst = 1'b1; word_in = '0; word_valid = 1'b0; clr_capture = 1'b0;
      repeat (3) @(negedge clk50);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", frame_cnt, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_flag", frame_done_flag, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_tmo", timeout_err, 0);
      chk("rst_w0", words_out[0], 0);
      chk("rst_w52", words_out[52], 0);
      rst = 1'b0;
      @(negedge clk50);

      // Good frame, one word every 4 clocks
      for (int k = 0; k < 53; k++) pay[k] = 10'(k);
      send_word(HDR, 4, 1'b0);
      chk("busy_data", busy, 1);
      for (int k = 0; k < 53; k++) send_word(pay[k], 4, 1'b0);
      chk("busy_trail", busy, 1);
      chk("no_early_done", frame_cnt, 0);
      send_word(TRL, 1, 1'b0);
      chk("done_lat1", frame_done, 1);
      chk("cnt_1", frame_cnt, 1);
      @(negedge clk50);
      chk("done_single", frame_done, 0);
      chk("flag_good", frame_done_flag, 1);
      chk("err_good", frame_err, 0);
      chk("busy_idle", busy, 0);
      chk("done_cnt_1", done_cnt, 1);
      for (int k = 0; k < 53; k++) chk($sformatf("good_w%0d", k), words_out[k], k);

      // Bad trailer
      pulse_clr();
      chk("clr_flag", frame_done_flag, 0);
      for (int k = 0; k < 53; k++) pay[k] = 10'h155;
      send_frame(10'h2AA, 1, 1'b0);
      @(negedge clk50);
      chk("bad_err", frame_err, 1);
      chk("bad_flag", frame_done_flag, 0);
      chk("bad_cnt", frame_cnt, 1);
      chk("bad_busy", busy, 0);
      chk("bad_w5", words_out[5], 5);
      chk("bad_w52", words_out[52], 52);
      chk("bad_done_cnt", done_cnt, 1);

      // A bad trailer equal to the header value must not start a new frame
      pulse_clr();
      chk("clr_err", frame_err, 0);
      send_frame(HDR, 1, 1'b0);
      chk("trl_hdr_busy", busy, 0);
      chk("trl_hdr_err", frame_err, 1);

      // Idle garbage, then a payload that holds the header and trailer values
      pulse_clr();
      send_word(TRL, 2, 1'b0);
      send_word(10'h155, 2, 1'b0);
      send_word(10'h000, 2, 1'b0);
      chk("garbage_busy", busy, 0);
      for (int k = 0; k < 53; k++) pay[k] = 10'(k + 100);
      pay[3]  = HDR;
      pay[40] = TRL;
      send_frame(TRL, 2, 1'b0);
      @(negedge clk50);
      chk("emb_cnt", frame_cnt, 2);
      chk("emb_flag", frame_done_flag, 1);
      chk("emb_err", frame_err, 0);
      chk("emb_w3", words_out[3], 10'h234);
      chk("emb_w40", words_out[40], 10'h2BF);
      chk("emb_w4", words_out[4], 104);
      chk("emb_w52", words_out[52], 152);
      chk("emb_done_cnt", done_cnt, 2);

      // Reset at payload word 20, then a full good frame
      send_word(HDR, 1, 1'b0);
      for (int k = 0; k < 20; k++) send_word(10'(k), 1, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk50);
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cnt", frame_cnt, 0);
      chk("mid_rst_flag", frame_done_flag, 0);
      chk("mid_rst_w3", words_out[3], 0);
      for (int k = 0; k < 53; k++) pay[k] = 10'(52 - k);
      send_frame(TRL, 1, 1'b0);
      @(negedge clk50);
      chk("post_rst_cnt", frame_cnt, 1);
      chk("post_rst_err", frame_err, 0);
      chk("post_rst_tmo", timeout_err, 0);
      chk("post_rst_flag", frame_done_flag, 1);
      chk("post_rst_w0", words_out[0], 52);

      // Run to 256 good frames; the last trailer comes with clr_capture
      for (int f = 0; f < 254; f++) send_frame(TRL, 1, 1'b0);
      @(negedge clk50);
      chk("cnt_255", frame_cnt, 255);
      pulse_clr();
      chk("clr_before_last", frame_done_flag, 0);
      send_frame(TRL, 1, 1'b1);
      chk("wrap_done", frame_done, 1);
      chk("wrap_cnt", frame_cnt, 0);
      chk("set_wins", frame_done_flag, 1);
      @(negedge clk50);
      chk("done_cnt_258", done_cnt, 258);

`ifdef CNT_CAPTURE_TIMEOUT_EN
      send_word(HDR, 1, 1'b0);
      for (int k = 0; k < 10; k++) send_word(10'(k), 1, 1'b0);
      repeat (1022) @(negedge clk50);
      chk("tmo_not_yet", timeout_err, 0);
      chk("tmo_busy_yet", busy, 1);
      @(negedge clk50);
      chk("tmo_err", timeout_err, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_w0", words_out[0], 52);
      for (int k = 0; k < 53; k++) pay[k] = 10'(k);
      send_frame(TRL, 1, 1'b0);
      chk("tmo_after_cnt", frame_cnt, 1);
      chk("tmo_after_w7", words_out[7], 7);
`else
      send_word(HDR, 1, 1'b0);
      for (int k = 0; k < 10; k++) send_word(10'(k), 1, 1'b0);
      repeat (1100) @(negedge clk50);
      chk("no_tmo_err", timeout_err, 0);
      chk("no_tmo_busy", busy, 1);
      for (int k = 10; k < 53; k++) send_word(10'(k), 1, 1'b0);
      send_word(TRL, 1, 1'b0);
      chk("no_tmo_cnt", frame_cnt, 1);
      chk("no_tmo_w9", words_out[9], 9);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
